// File: rtl/hood_mode_scheduler.sv
// Range-hood fan mode sequencer: standby/menu/levels/hurricane/self-clean with second-tick countdowns.
// Optional macro HURRICANE_LIMIT_EN: allow level 3 only once per power session.
module hood_mode_scheduler #(
    parameter int SECOND        = 100_000_000,
    parameter int HURRICANE_SEC = 60,
    parameter int CLEAN_SEC     = 180,
    parameter int RETURN_SEC    = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_machine_state,
    input  logic        i_menu_btn,
    input  logic        i_level1_btn,
    input  logic        i_level2_btn,
    input  logic        i_level3_btn,
    input  logic        i_clean_btn,
    output logic [2:0]  o_mode_state,
    output logic [1:0]  o_fan_level,
    output logic [7:0]  o_countdown,
    output logic        o_hurricane_used,
    output logic        o_clean_done,
    output logic [31:0] o_time_data
);
    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_STANDBY = 3'd1;
    localparam logic [2:0] S_MENU    = 3'd2;
    localparam logic [2:0] S_L1      = 3'd3;
    localparam logic [2:0] S_L2      = 3'd4;
    localparam logic [2:0] S_L3      = 3'd5;
    localparam logic [2:0] S_RETURN  = 3'd6;
    localparam logic [2:0] S_CLEAN   = 3'd7;

    localparam int TW = (SECOND > 1) ? $clog2(SECOND) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SECOND - 1);
    localparam logic [7:0] HUR_LOAD   = (HURRICANE_SEC > 255) ? 8'd255 : 8'(HURRICANE_SEC);
    localparam logic [7:0] CLEAN_LOAD = (CLEAN_SEC > 255)     ? 8'd255 : 8'(CLEAN_SEC);
    localparam logic [7:0] RET_LOAD   = (RETURN_SEC > 255)    ? 8'd255 : 8'(RETURN_SEC);

    logic [2:0]    r_state;
    logic [7:0]    r_cnt;
    logic          r_hu;
    logic          r_done;
    logic [1:0]    r_fan;
    logic [31:0]   r_time;
    logic [TW-1:0] r_tick;

    logic [2:0]    w_next_state;
    logic [7:0]    w_next_cnt;
    logic          w_next_hu;
    logic          w_next_done;
    logic [1:0]    w_next_fan;
    logic [31:0]   w_next_time;
    logic          w_timed;
    logic          w_tick;
    logic          w_last;
    logic [7:0]    w_dec;
    logic          w_l3_ok;

`ifdef HURRICANE_LIMIT_EN
    assign w_l3_ok = !r_hu;
`else
    assign w_l3_ok = 1'b1;
`endif

    assign w_timed = (r_state == S_L3) || (r_state == S_RETURN) || (r_state == S_CLEAN);
    assign w_tick  = w_timed && (r_tick == TICK_LAST);
    assign w_last  = (r_cnt <= 8'd1);
    assign w_dec   = (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_OFF;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_hu    = r_hu;
        w_next_done  = 1'b0;
        if (!i_machine_state) begin
            w_next_state = S_OFF;
            w_next_cnt   = 8'd0;
            w_next_hu    = 1'b0;
        end else begin
            case (r_state)
                S_OFF:     w_next_state = S_STANDBY;
                S_STANDBY: if (i_menu_btn) w_next_state = S_MENU;
                S_MENU: begin
                    if (i_menu_btn) w_next_state = S_STANDBY;
                    else if (i_clean_btn) begin
                        w_next_state = S_CLEAN;
                        w_next_cnt   = CLEAN_LOAD;
                    end else if (i_level3_btn && w_l3_ok) begin
                        w_next_state = S_L3;
                        w_next_cnt   = HUR_LOAD;
                        w_next_hu    = 1'b1;
                    end else if (i_level2_btn) w_next_state = S_L2;
                    else if (i_level1_btn) w_next_state = S_L1;
                end
                S_L1: begin
                    if (i_menu_btn)        w_next_state = S_STANDBY;
                    else if (i_level2_btn) w_next_state = S_L2;
                end
                S_L2: begin
                    if (i_menu_btn)        w_next_state = S_STANDBY;
                    else if (i_level1_btn) w_next_state = S_L1;
                end
                S_L3: begin
                    if (i_menu_btn) begin
                        w_next_state = S_RETURN;
                        w_next_cnt   = RET_LOAD;
                    end else if (w_tick) begin
                        w_next_cnt = w_dec;
                        if (w_last) w_next_state = S_L2;
                    end
                end
                S_RETURN: if (w_tick) begin
                    w_next_cnt = w_dec;
                    if (w_last) w_next_state = S_STANDBY;
                end
                S_CLEAN: if (w_tick) begin
                    w_next_cnt = w_dec;
                    if (w_last) begin
                        w_next_state = S_STANDBY;
                        w_next_done  = 1'b1;
                    end
                end
                default: w_next_state = S_OFF;
            endcase
        end
    end

    // Output values are computed from the next state so every output register updates together.
    always_comb begin
        w_next_fan = 2'd0;
        case (w_next_state)
            S_L1:               w_next_fan = 2'd1;
            S_L2, S_RETURN:     w_next_fan = 2'd2;
            S_L3, S_CLEAN:      w_next_fan = 2'd3;
            default:            w_next_fan = 2'd0;
        endcase
        w_next_time = {12'hFFF, 1'b0, w_next_state, 4'hF,
                       4'(w_next_cnt / 8'd100),
                       4'((w_next_cnt / 8'd10) % 8'd10),
                       4'(w_next_cnt % 8'd10)};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= 8'd0;
            r_hu   <= 1'b0;
            r_done <= 1'b0;
            r_fan  <= 2'd0;
            r_time <= 32'hFFFF_FF00;
        end else begin
            r_cnt  <= w_next_cnt;
            r_hu   <= w_next_hu;
            r_done <= w_next_done;
            r_fan  <= w_next_fan;
            r_time <= w_next_time;
        end
    end

    // Tick counter restarts on every state entry so a new timed mode gets a full first second.
    always_ff @(posedge i_clk) begin
        if (i_rst)                                    r_tick <= '0;
        else if ((w_next_state != r_state) || !w_timed) r_tick <= '0;
        else if (w_tick)                              r_tick <= '0;
        else                                          r_tick <= r_tick + 1'b1;
    end

    assign o_mode_state     = r_state;
    assign o_fan_level      = r_fan;
    assign o_countdown      = r_cnt;
    assign o_hurricane_used = r_hu;
    assign o_clean_done     = r_done;
    assign o_time_data      = r_time;
endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Self-checking bench for hood_mode_scheduler: directed scenarios plus random buttons against a behavioural model.
module tb_hood_mode_scheduler;
    localparam int SEC = 10;
    localparam int M_OFF = 0, M_STBY = 1, M_MENU = 2, M_L1 = 3, M_L2 = 4, M_L3 = 5, M_RET = 6, M_CLEAN = 7;
    localparam logic [4:0] B_MENU = 5'b10000, B_CLEAN = 5'b01000, B_L3 = 5'b00100,
                           B_L2 = 5'b00010, B_L1 = 5'b00001, B_NONE = 5'b00000;

    logic clk = 1'b0, rst = 1'b1, ms = 1'b0;
    logic menu = 1'b0, l1 = 1'b0, l2 = 1'b0, l3 = 1'b0, clean = 1'b0;
    logic [2:0]  o_mode_state;
    logic [1:0]  o_fan_level;
    logic [7:0]  o_countdown;
    logic        o_hurricane_used, o_clean_done;
    logic [31:0] o_time_data;
    logic [46:0] obs;

    int checks = 0, failures = 0;
    int m_mode = 0, m_cnt = 0, m_sub = 0;
    bit m_hu = 0, m_done = 0, m_blank = 1;

    hood_mode_scheduler #(.SECOND(SEC), .HURRICANE_SEC(60), .CLEAN_SEC(180), .RETURN_SEC(60)) dut (
        .i_clk(clk), .i_rst(rst), .i_machine_state(ms),
        .i_menu_btn(menu), .i_level1_btn(l1), .i_level2_btn(l2), .i_level3_btn(l3), .i_clean_btn(clean),
        .o_mode_state(o_mode_state), .o_fan_level(o_fan_level), .o_countdown(o_countdown),
        .o_hurricane_used(o_hurricane_used), .o_clean_done(o_clean_done), .o_time_data(o_time_data)
    );

    always #5 clk = ~clk;

    assign obs = {o_mode_state, o_fan_level, o_countdown, o_hurricane_used, o_clean_done, o_time_data};

    function automatic logic [46:0] model_out();
        logic [1:0]  fan;
        logic [31:0] td;
        logic [2:0]  md;
        md  = 3'(m_mode);
        fan = (m_mode == M_L1) ? 2'd1 :
              (m_mode == M_L2 || m_mode == M_RET) ? 2'd2 :
              (m_mode == M_L3 || m_mode == M_CLEAN) ? 2'd3 : 2'd0;
        td  = m_blank ? 32'hFFFF_FF00 :
              {12'hFFF, 1'b0, md, 4'hF, 4'(m_cnt / 100), 4'((m_cnt / 10) % 10), 4'(m_cnt % 10)};
        return {md, fan, 8'(m_cnt), m_hu, m_done, td};
    endfunction

    // One clock: drive inputs, advance the reference model by the spec rules, sample 1ns after the edge.
    task automatic step(input logic ms_i, input logic [4:0] b, input logic r);
        int prev;
        bit sec, timed, l3_ok;
        ms = ms_i; rst = r;
        {menu, clean, l3, l2, l1} = b;
        @(posedge clk);
        if (r) begin
            m_mode = M_OFF; m_cnt = 0; m_sub = 0; m_hu = 0; m_done = 0; m_blank = 1;
        end else begin
            prev  = m_mode;
            timed = (m_mode == M_L3 || m_mode == M_RET || m_mode == M_CLEAN);
            sec   = timed && (m_sub == SEC - 1);
`ifdef HURRICANE_LIMIT_EN
            l3_ok = !m_hu;
`else
            l3_ok = 1;
`endif
            m_done = 0; m_blank = 0;
            if (!ms_i) begin
                m_mode = M_OFF; m_cnt = 0; m_hu = 0;
            end else if (m_mode == M_OFF) m_mode = M_STBY;
            else if (m_mode == M_STBY) begin
                if (b[4]) m_mode = M_MENU;
            end else if (m_mode == M_MENU) begin
                if (b[4]) m_mode = M_STBY;
                else if (b[3]) begin m_mode = M_CLEAN; m_cnt = 180; end
                else if (b[2] && l3_ok) begin m_mode = M_L3; m_cnt = 60; m_hu = 1; end
                else if (b[1]) m_mode = M_L2;
                else if (b[0]) m_mode = M_L1;
            end else if (m_mode == M_L1 || m_mode == M_L2) begin
                if (b[4]) m_mode = M_STBY;
                else if (m_mode == M_L1 && b[1]) m_mode = M_L2;
                else if (m_mode == M_L2 && b[0]) m_mode = M_L1;
            end else if (m_mode == M_L3 && b[4]) begin
                m_mode = M_RET; m_cnt = 60;
            end else if (sec) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    if (m_mode == M_L3) m_mode = M_L2;
                    else begin
                        if (m_mode == M_CLEAN) m_done = 1;
                        m_mode = M_STBY;
                    end
                end
            end
            if (m_mode != prev) m_sub = 0;
            else if (timed)     m_sub = (m_sub + 1) % SEC;
            else                m_sub = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, B_NONE, 1);
        step(1, B_MENU, 1);
        checks++;
        if (obs !== {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 32'hFFFF_FF00}) begin
            failures++; $display("FAIL reset_state got=%h want=%h", obs, {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 32'hFFFF_FF00});
        end
        step(1, B_NONE, 0);
        checks++;
        if (o_mode_state !== 3'd1 || o_time_data !== 32'hFFF1_F000 || obs !== model_out()) begin
            failures++; $display("FAIL reset_to_standby got=%h want=%h", obs, model_out());
        end
    endtask

    task automatic test_power_up();
        logic [4:0] seq [6] = '{B_L2 | B_L3 | B_CLEAN | B_L1, B_MENU, B_L2, B_L1, B_L3, B_MENU};
        logic [2:0] wm  [6] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd1};
        logic [1:0] wf  [6] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 6; i++) begin
            step(1, seq[i], 0);
            checks++;
            if (o_mode_state !== wm[i] || o_fan_level !== wf[i] || obs !== model_out()) begin
                failures++;
                $display("FAIL power_up[%0d] got mode=%0d fan=%0d obs=%h want mode=%0d fan=%0d obs=%h",
                         i, o_mode_state, o_fan_level, obs, wm[i], wf[i], model_out());
            end
        end
    endtask

    task automatic test_hurricane();
        int bad = 0;
        step(1, B_MENU, 0);
        step(1, B_L3, 0);
        checks++;
        if (o_mode_state !== 3'd5 || o_countdown !== 8'd60 || o_fan_level !== 2'd3 ||
            o_time_data[7:0] !== 8'h60 || o_hurricane_used !== 1'b1) begin
            failures++; $display("FAIL hurricane_entry got=%h want mode=5 cnt=60 fan=3 td=60", obs);
        end
        for (int i = 0; i < 600; i++) begin
            step(1, B_NONE, 0);
            if (obs !== model_out()) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL hurricane_run mismatching_cycles=%0d want=0", bad); end
        checks++;
        if (o_mode_state !== 3'd4 || o_countdown !== 8'd0 || o_fan_level !== 2'd2) begin
            failures++; $display("FAIL hurricane_expiry got mode=%0d cnt=%0d want mode=4 cnt=0", o_mode_state, o_countdown);
        end
    endtask

    task automatic test_return();
        int bad = 0, n = 0;
        step(0, B_NONE, 0);
        step(1, B_NONE, 0);
        step(1, B_MENU, 0);
        step(1, B_L3, 0);
        while (o_countdown !== 8'd45 && n < 300) begin
            step(1, B_NONE, 0);
            if (obs !== model_out()) bad++;
            n++;
        end
        checks++;
        if (n >= 300) begin failures++; $display("FAIL return_wait45 got cnt=%0d want=45 (timeout)", o_countdown); end
        step(1, B_MENU, 0);
        checks++;
        if (o_mode_state !== 3'd6 || o_countdown !== 8'd60 || o_fan_level !== 2'd2 || obs !== model_out()) begin
            failures++; $display("FAIL return_entry got=%h want=%h", obs, model_out());
        end
        for (int i = 0; i < 600; i++) begin
            step(1, B_NONE, 0);
            if (obs !== model_out()) bad++;
        end
        checks++;
        if (bad != 0 || o_mode_state !== 3'd1 || o_fan_level !== 2'd0 || o_countdown !== 8'd0) begin
            failures++; $display("FAIL return_expiry got mode=%0d fan=%0d bad=%0d want mode=1 fan=0 bad=0",
                                 o_mode_state, o_fan_level, bad);
        end
    endtask

    task automatic test_hurricane_repeat();
        step(1, B_MENU, 0);
        step(1, B_L3, 0);
        checks++;
`ifdef HURRICANE_LIMIT_EN
        if (o_mode_state !== 3'd2 || obs !== model_out()) begin
            failures++; $display("FAIL hurricane_limit got mode=%0d want=2", o_mode_state);
        end
`else
        if (o_mode_state !== 3'd5 || obs !== model_out()) begin
            failures++; $display("FAIL hurricane_repeat got mode=%0d want=5", o_mode_state);
        end
`endif
        step(0, B_L3, 0);
        checks++;
        if (o_hurricane_used !== 1'b0 || o_mode_state !== 3'd0) begin
            failures++; $display("FAIL hurricane_clear got hu=%0b mode=%0d want hu=0 mode=0", o_hurricane_used, o_mode_state);
        end
        step(1, B_NONE, 0);
        step(1, B_MENU, 0);
        step(1, B_L3, 0);
        checks++;
        if (o_mode_state !== 3'd5 || o_hurricane_used !== 1'b1 || obs !== model_out()) begin
            failures++; $display("FAIL hurricane_new_session got mode=%0d hu=%0b want mode=5 hu=1", o_mode_state, o_hurricane_used);
        end
        step(0, B_NONE, 0);
        step(1, B_NONE, 0);
    endtask

    task automatic test_clean();
        int bad = 0, pulses = 0;
        step(1, B_MENU, 0);
        step(1, B_CLEAN, 0);
        checks++;
        if (o_mode_state !== 3'd7 || o_countdown !== 8'd180 || o_time_data[11:0] !== 12'h180 || o_fan_level !== 2'd3) begin
            failures++; $display("FAIL clean_entry got=%h want mode=7 cnt=180 td=180 fan=3", obs);
        end
        for (int i = 0; i < 1800; i++) begin
            step(1, 5'($urandom_range(0, 31)) & (B_L1 | B_L2 | B_L3 | B_MENU | B_CLEAN), 0);
            if (obs !== model_out()) bad++;
            if (o_clean_done === 1'b1) pulses++;
        end
        checks++;
        if (bad != 0 || o_mode_state !== 3'd1 || pulses != 1) begin
            failures++; $display("FAIL clean_run got mode=%0d pulses=%0d bad=%0d want mode=1 pulses=1 bad=0",
                                 o_mode_state, pulses, bad);
        end
        step(1, B_NONE, 0);
        checks++;
        if (o_clean_done !== 1'b0) begin failures++; $display("FAIL clean_done_width got=1 want=0"); end
    endtask

    task automatic test_power_drop();
        int n = 0;
        step(1, B_MENU, 0);
        step(1, B_CLEAN, 0);
        while (o_countdown !== 8'd100 && n < 1000) begin step(1, B_NONE, 0); n++; end
        checks++;
        if (n >= 1000) begin failures++; $display("FAIL drop_wait100 got cnt=%0d want=100 (timeout)", o_countdown); end
        step(0, B_MENU | B_CLEAN, 0);
        checks++;
        if (o_mode_state !== 3'd0 || o_countdown !== 8'd0 || o_fan_level !== 2'd0 || o_clean_done !== 1'b0 ||
            obs !== model_out()) begin
            failures++; $display("FAIL power_drop got=%h want=%h", obs, model_out());
        end
        step(1, B_NONE, 0);
    endtask

    task automatic test_priority();
        logic [4:0] combo [4] = '{B_MENU | B_CLEAN, B_CLEAN | B_L3 | B_L2, B_L3 | B_L2 | B_L1, B_L2 | B_L1};
        logic [2:0] wm    [4] = '{3'd1, 3'd7, 3'd5, 3'd4};
        for (int i = 0; i < 4; i++) begin
            step(0, B_NONE, 0);
            step(1, B_NONE, 0);
            step(1, B_MENU, 0);
            step(1, combo[i], 0);
            checks++;
            if (o_mode_state !== wm[i] || obs !== model_out()) begin
                failures++; $display("FAIL priority[%0d] got mode=%0d want=%0d", i, o_mode_state, wm[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, B_NONE, 0);
        step(1, B_NONE, 0);
        step(1, B_MENU, 0);
        step(1, B_L3, 0);
        for (int i = 0; i < 25; i++) step(1, B_NONE, 0);
        step(1, B_MENU, 1);
        checks++;
        if (obs !== {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 32'hFFFF_FF00}) begin
            failures++; $display("FAIL reset_mid got=%h want=%h", obs, {3'd0, 2'd0, 8'd0, 1'b0, 1'b0, 32'hFFFF_FF00});
        end
        step(1, B_NONE, 0);
        checks++;
        if (o_mode_state !== 3'd1 || obs !== model_out()) begin
            failures++; $display("FAIL reset_mid_standby got mode=%0d want=1", o_mode_state);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        logic [4:0] b;
        for (int i = 0; i < 4000; i++) begin
            b = 5'd0;
            for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 11) == 0);
            step($urandom_range(0, 299) != 0, b, $urandom_range(0, 799) == 0);
            checks++;
            if (obs !== model_out()) begin
                failures++;
                if (shown < 5) $display("FAIL random[%0d] got=%h want=%h", i, obs, model_out());
                shown++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_hurricane();
        test_return();
        test_hurricane_repeat();
        test_clean();
        test_power_drop();
        test_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hood_mode_scheduler.md
Name: hood_mode_scheduler

Overview:
- Sequences the range-hood fan modes once the power controller reports the machine is on: standby, menu, suction levels 1–3 and timed self-clean.
- Enforces timed modes: hurricane (level 3) and self-clean run from a one-second-tick countdown.
- Drives the fan level to the motor driver and packs mode and countdown into a 32-bit word for the seven-segment time display.

Parameters:
- SECOND, 100_000_000, clk cycles per second tick (benches override with a small value, e.g. 10).
- HURRICANE_SEC, 60, level-3 run time in seconds.
- CLEAN_SEC, 180, self-clean run time in seconds.
- RETURN_SEC, 60, level-2 run-down time after hurricane is cancelled early.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- machine_state, input, 1, power state from the on/off controller (1 = on).
- menu_btn, input, 1, one-cycle debounced pulse.
- level1_btn, input, 1, one-cycle pulse.
- level2_btn, input, 1, one-cycle pulse.
- level3_btn, input, 1, one-cycle pulse.
- clean_btn, input, 1, one-cycle pulse.
- mode_state, output, 3, 0 OFF, 1 STANDBY, 2 MENU, 3 L1, 4 L2, 5 L3, 6 RETURN, 7 CLEAN.
- fan_level, output, 2, motor speed 0–3.
- countdown, output, 8, remaining seconds of the current timed mode; 0 otherwise.
- hurricane_used, output, 1, level 3 consumed in this power session.
- clean_done, output, 1, one-cycle pulse when self-clean completes.
- time_data, output, 32, display word.

Behaviour:
- Reset (sync, rst=1): mode_state=OFF, fan_level=0, countdown=0, hurricane_used=0, clean_done=0, tick counter=0.
  - time_data holds its blank pattern: every nibble 4'b1111, except [3:0]=0 and [7:4]=0.
- All outputs are registered; state changes become visible one cycle after the causing input.
- machine_state=0 in any state → OFF next cycle. This clears countdown, fan_level and hurricane_used; it has priority over every button.
- OFF → STANDBY on the first cycle machine_state=1.
- STANDBY: menu_btn → MENU. Other buttons are ignored.
- MENU:
  - level1_btn → L1; level2_btn → L2.
  - level3_btn → L3 when permitted; countdown=HURRICANE_SEC; hurricane_used=1.
  - clean_btn → CLEAN; countdown=CLEAN_SEC.
  - menu_btn → STANDBY.
- Simultaneous buttons priority: menu > clean > level3 > level2 > level1.
- L1/L2:
  - The other of level1_btn/level2_btn switches directly between L1 and L2.
  - menu_btn → STANDBY.
  - level3_btn and clean_btn are ignored.
- L3:
  - Countdown decrements on each second tick.
  - Tick at countdown=1 → countdown=0 and state → L2 the same cycle.
  - menu_btn → RETURN; countdown=RETURN_SEC.
- RETURN: fan_level=2; counts down; reaching 0 → STANDBY.
- CLEAN:
  - fan_level=3; counts down; all buttons ignored.
  - Reaching 0 → STANDBY with clean_done=1 for exactly one cycle.
- fan_level per state: OFF/STANDBY/MENU → 0; L1 → 1; L2 → 2; L3 → 3; RETURN → 2; CLEAN → 3.
- Tick counter:
  - Runs only in L3, RETURN and CLEAN.
  - Counts 0..SECOND-1; the tick fires at SECOND-1, then the counter wraps to 0.
  - Reset to 0 on every state entry, so each timed mode gets a full first second.
- countdown width is 8 bits. Parameters above 255 are not supported and are clamped to 255 at load.
- time_data nibble layout:
  - [3:0] countdown ones; [7:4] tens; [11:8] hundreds.
  - [15:12] = 4'b1111.
  - [19:16] = mode_state.
  - [31:20] = all 4'b1111 (blank).
  - Digits update in the same cycle as countdown.
- Reset mid-mode returns to OFF; machine_state still high → STANDBY the cycle after rst drops.

Optional Feature:
- Macro HURRICANE_LIMIT_EN.
- Defined: level3_btn in MENU is accepted only while hurricane_used=0; otherwise it is ignored and the state stays MENU.
- Undefined: level 3 may be entered any number of times per session. hurricane_used is still set on entry but is not checked.

Test Plan:
- Power up with SECOND=10: rst then machine_state=1 → STANDBY; menu_btn → MENU, fan_level=0; level2_btn → L2, fan_level=2.
- MENU, level3_btn → L3, countdown=60, fan_level=3, time_data[7:0]=8'h60. After 600 cycles → L2, countdown=0.
- L3 at countdown=45, menu_btn → RETURN, countdown=60, fan_level=2. After 600 cycles → STANDBY, fan_level=0.
- HURRICANE_LIMIT_EN defined: after one L3 run, MENU + level3_btn → stays MENU. Drop machine_state, raise it again, MENU + level3_btn → L3 accepted.
- CLEAN: clean_btn in MENU → countdown=180, time_data[11:0]=12'h180, level buttons ignored. After 1800 cycles → STANDBY with a single-cycle clean_done.
- machine_state=0 during CLEAN at countdown=100 → OFF next cycle, countdown=0, fan_level=0, no clean_done. Simultaneous menu_btn+clean_btn in MENU → STANDBY.
